// File: rtl/v_shift_registers_dyn_if.sv
// Bus interface for the dynamic shift register: control, serial data, tap address and observed outputs.
interface v_shift_registers_dyn_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 4
);
  logic             ce;
  logic             sclr;
  logic [1:0]       mode;
  logic [WIDTH-1:0] si;
  logic [AW-1:0]    addr;
  logic [WIDTH-1:0] so_l;
  logic [WIDTH-1:0] so_r;
  logic [WIDTH-1:0] tap_q;
  logic             tap_err;
  logic [AW:0]      fill;
  logic             full;

  // Driver side: issues control and data, observes outputs
  modport master (
    output ce, sclr, mode, si, addr,
    input  so_l, so_r, tap_q, tap_err, fill, full
  );

  // Shift register side
  modport slave (
    input  ce, sclr, mode, si, addr,
    output so_l, so_r, tap_q, tap_err, fill, full
  );
endinterface

// File: rtl/v_shift_registers_dyn.sv
// Multi-bit shift register with per-cycle shift mode, registered dynamic tap and saturating fill count.
module v_shift_registers_dyn #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  v_shift_registers_dyn_if.slave bus
);

  localparam int unsigned FW = AW + 1;

  // Tap address must be able to reach every stage
  if ((2 ** AW) < DEPTH) begin : g_aw_chk
    $error("v_shift_registers_dyn: 2**AW must be >= DEPTH");
  end

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];
  logic [FW-1:0]    fill_q,    fill_d;
  logic [WIDTH-1:0] tap_q,     tap_d;
  logic             tap_err_q, tap_err_d;

  // Next stage contents and fill count: clear beats enabled shift beats hold
  always_comb begin
    stage_d = stage_q;
    fill_d  = fill_q;
    if (bus.sclr) begin
      for (int i = 0; i < DEPTH; i++) stage_d[i] = '0;
      fill_d = '0;
    end else if (bus.ce) begin
      unique case (bus.mode)
        2'b00: ;
        2'b01: begin
          stage_d[0] = bus.si;
          for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
        end
        2'b10: begin
          stage_d[DEPTH-1] = bus.si;
          for (int i = 0; i < DEPTH - 1; i++) stage_d[i] = stage_q[i+1];
        end
        2'b11: begin
          stage_d[0] = stage_q[DEPTH-1];
          for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
        end
        default: ;
      endcase
      // Fill counts shift events (either direction), saturating at DEPTH
      if ((bus.mode == 2'b01 || bus.mode == 2'b10) && fill_q != FW'(DEPTH))
        fill_d = fill_q + FW'(1);
    end
  end

  // Dynamic tap: reads pre-edge contents every cycle; out-of-range address flags an error
  always_comb begin
    tap_d     = '0;
    tap_err_d = ({1'b0, bus.addr} >= FW'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.addr == AW'(i)) tap_d = stage_q[i];
    end
    if (bus.sclr) begin
      tap_d     = '0;
      tap_err_d = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      fill_q    <= '0;
      tap_q     <= '0;
      tap_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= stage_d[i];
      fill_q    <= fill_d;
      tap_q     <= tap_d;
      tap_err_q <= tap_err_d;
    end
  end

  assign bus.so_l    = stage_q[DEPTH-1];
  assign bus.so_r    = stage_q[0];
  assign bus.tap_q   = tap_q;
  assign bus.tap_err = tap_err_q;
  assign bus.fill    = fill_q;
  assign bus.full    = (fill_q == FW'(DEPTH));

endmodule

// File: tb/tb_v_shift_registers_dyn.sv
// Randomized bench for v_shift_registers_dyn against a queue-based reference model.
module tb_v_shift_registers_dyn;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 12;
  localparam int unsigned AW    = 4;

  logic clk;
  logic rst_n;

  v_shift_registers_dyn_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

  v_shift_registers_dyn #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: mq[0] is stage[0], mq[DEPTH-1] is stage[DEPTH-1]
  logic [WIDTH-1:0] mq[$];
  int               mfill;
  logic [WIDTH-1:0] mtap;
  logic             merr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    for (int i = 0; i < DEPTH; i++) mq.push_back('0);
    mfill = 0;
    mtap  = '0;
    merr  = 1'b0;
  endtask

  // Applies the rules for one rising edge using the inputs sampled there
  task automatic model_edge(input logic ce, input logic sclr, input logic [1:0] mode,
                            input logic [WIDTH-1:0] si, input logic [AW-1:0] addr);
    logic [WIDTH-1:0] t;
    mtap = (int'(addr) < DEPTH) ? mq[addr] : '0;
    merr = (int'(addr) >= DEPTH);
    if (sclr) begin
      model_clear();
    end else if (ce) begin
      case (mode)
        2'b01: begin mq.push_front(si); void'(mq.pop_back());  end
        2'b10: begin mq.push_back(si);  void'(mq.pop_front()); end
        2'b11: begin t = mq.pop_back(); mq.push_front(t);      end
        default: ;
      endcase
      if ((mode == 2'b01 || mode == 2'b10) && mfill < DEPTH) mfill++;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".so_l"},    32'(bus.so_l),    32'(mq[DEPTH-1]));
    chk({tag, ".so_r"},    32'(bus.so_r),    32'(mq[0]));
    chk({tag, ".tap_q"},   32'(bus.tap_q),   32'(mtap));
    chk({tag, ".tap_err"}, 32'(bus.tap_err), 32'(merr));
    chk({tag, ".fill"},    32'(bus.fill),    32'(mfill));
    chk({tag, ".full"},    32'(bus.full),    32'(mfill == DEPTH));
  endtask

  // One clocked step: drive, take the edge, update model, check 1ns after
  task automatic step(input string tag, input logic ce, input logic sclr, input logic [1:0] mode,
                      input logic [WIDTH-1:0] si, input logic [AW-1:0] addr);
    bus.ce = ce; bus.sclr = sclr; bus.mode = mode; bus.si = si; bus.addr = addr;
    @(posedge clk);
    model_edge(ce, sclr, mode, si, addr);
    #1;
    check_all(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.ce = 1'b0; bus.sclr = 1'b0; bus.mode = 2'b00; bus.si = '0; bus.addr = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Load stage[k] = k with shift-left, fill climbs to DEPTH
    for (int i = 0; i < DEPTH; i++)
      step("load", 1'b1, 1'b0, 2'b01, WIDTH'(DEPTH - 1 - i), AW'(0));
    chk("full_after_load", 32'(bus.full), 32'd1);

    // Tap read, out-of-range tap, and tap on a shifting edge returns pre-shift data
    step("tap5", 1'b0, 1'b0, 2'b00, '0, AW'(5));
    chk("tap5_const", 32'(bus.tap_q), 32'd5);
    step("tap13", 1'b0, 1'b0, 2'b00, '0, AW'(13));
    chk("tap13_err", 32'(bus.tap_err), 32'd1);
    step("tap5_shift", 1'b1, 1'b0, 2'b01, 8'hEE, AW'(5));
    chk("tap5_preshift", 32'(bus.tap_q), 32'd5);

    // Rotate DEPTH times returns the contents; fill unchanged
    for (int i = 0; i < DEPTH; i++)
      step("rot", 1'b1, 1'b0, 2'b11, 8'hFF, AW'(i));

    // Clear with ce=1 and shift-left: clear wins, si not captured
    step("sclr_ce", 1'b1, 1'b1, 2'b01, 8'h5A, AW'(3));
    chk("sclr_fill", 32'(bus.fill), 32'd0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic ce_r, sclr_r;
      ce_r   = ($urandom_range(0, 9) < 8);
      sclr_r = ($urandom_range(0, 39) == 0);
      step("rand", ce_r, sclr_r, 2'($urandom), WIDTH'($urandom), AW'($urandom));
    end

    // Asynchronous reset between edges with fill=3
    step("pre_rst_clr", 1'b0, 1'b1, 2'b00, '0, '0);
    for (int i = 0; i < 3; i++)
      step("pre_rst", 1'b1, 1'b0, 2'b10, WIDTH'(8'hC0 + i), AW'(DEPTH - 1));
    chk("fill3", 32'(bus.fill), 32'd3);
    #3;
    rst_n = 1'b0;
    model_clear();
    #1;
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst", 1'b1, 1'b0, 2'b01, 8'h77, '0);
    chk("post_rst_fill", 32'(bus.fill), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/v_shift_registers_dyn.md
Name: v_shift_registers_dyn

Overview:
Parametrised multi-bit shift register: DEPTH stages of WIDTH bits each, with clock enable and a synchronous clear.
- Shift mode is selectable per cycle: hold, shift-left, shift-right or rotate.
- A registered dynamic tap reads any stage by address.
- A saturating fill counter reports how many stages hold shifted-in data.
- Generalises the fixed 8-stage, 1-bit serial shift register; used for delay lines, serial/parallel staging and variable-latency alignment.

Parameters:
WIDTH, 8, bits per stage (>=1)
DEPTH, 16, number of stages (>=2)
AW, 4, tap address width; 2**AW >= DEPTH required (elaboration error otherwise)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
ce  in  1  active-high clock enable for shift/rotate
sclr  in  1  synchronous clear, active high, independent of ce
mode  in  2  00 hold, 01 shift-left, 10 shift-right, 11 rotate-left
si  in  WIDTH  serial data input
addr  in  AW  dynamic tap stage index
so_l  out  WIDTH  stage[DEPTH-1], combinational from register
so_r  out  WIDTH  stage[0], combinational from register
tap_q  out  WIDTH  registered stage[addr]
tap_err  out  1  registered: addr >= DEPTH in the sampled cycle
fill  out  AW+1  valid-stage count, 0..DEPTH
full  out  1  fill == DEPTH (combinational from fill)

Behaviour:
- Reset (rst_n=0, asynchronous): all stages, tap_q, tap_err and fill clear to 0. Outputs so_l=0, so_r=0, full=0. Release is synchronous to clk; the first active edge after deassertion operates normally.
- Priority each edge: sclr > (ce & mode) > hold.
- sclr=1: all stages, tap_q and fill go to 0; tap_err goes to 0. Applies whether ce is 0 or 1.
- ce=0 or mode=00: stages and fill hold.
- mode=01 (shift-left): stage[0]<=si; stage[i]<=stage[i-1] for i=1..DEPTH-1; the old stage[DEPTH-1] is discarded.
- mode=10 (shift-right): stage[DEPTH-1]<=si; stage[i]<=stage[i+1]; the old stage[0] is discarded.
- mode=11 (rotate-left): stage[0]<=old stage[DEPTH-1]; the others shift as in mode 01; si is ignored; fill is unchanged.
- fill:
  - Increments by 1 on every enabled mode 01 or 10 edge.
  - Saturates at DEPTH; no wrap.
  - Mixing directions still increments; fill counts shift events, not data positions.
- so_l/so_r latency: a value on si appears on so_l exactly DEPTH enabled mode-01 edges later, and on so_r DEPTH enabled mode-10 edges later.
- Tap path:
  - Evaluated every edge regardless of ce.
  - tap_q <= stage[addr] using the pre-edge stage contents.
  - For addr >= DEPTH: tap_q <= 0 and tap_err <= 1; otherwise tap_err <= 0.
  - Read latency is 1 cycle.
  - When a shift and a tap read occur on the same edge, the tap returns the old value.
- X/undefined mode values are not expected; mode is decoded fully with no default latch.
- No combinational path from si or addr to any output.

Test Plan:
1. DEPTH=4, WIDTH=8, mode=01, ce=1; drive si=0x11,0x22,0x33,0x44,0x55 on 5 edges -> so_l=0x11 after edge 4 and 0x22 after edge 5; fill=1,2,3,4,4; full asserts after edge 4.
2. From the state of test 1 (stages[0..3]=0x55,0x44,0x33,0x22), mode=11 for 4 edges -> after 1 edge stage[0]=0x22 and so_l=0x33; after 4 edges contents are back to the original; fill stays 4.
3. DEPTH=4, mode=10; si=0xA0,0xA1,0xA2,0xA3 -> so_r=0xA0 after edge 4. Toggle ce=0 for 3 edges -> so_r and fill unchanged.
4. DEPTH=12, AW=4, stages loaded 0x00..0x0B via shift-left; addr=5 -> tap_q=stage[5] one cycle later with tap_err=0. addr=13 -> tap_q=0, tap_err=1 next cycle. Shift on the same edge as addr=5 -> tap_q returns the pre-shift stage[5].
5. sclr=1 with ce=0 mid-stream -> next edge: all stages 0, fill=0, full=0, tap_q=0. sclr=1 with ce=1 and mode=01 on the same edge -> clear wins, and si is not captured.
6. Assert rst_n=0 between clock edges while fill=3 -> outputs go to 0 immediately, without waiting for clk. Deassert, then shift once -> fill=1.
